// File: rtl/regfile_pkg.sv
// Shared constants, field positions and decode helpers for the register-file operand stage.
// Consumers: reg_array and reg_file_decode (optional REGFILE_BYPASS_EN lives in reg_file_decode).
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int INSTR_W  = 32;

  localparam logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0000;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    DST_RT = 1'b0,
    DST_RD = 1'b1
  } dst_sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
  } reg_fields_t;

  function automatic reg_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
    reg_fields_t f;
    f.rs = instr[RS_HI:RS_LO];
    f.rt = instr[RT_HI:RT_LO];
    f.rd = instr[RD_HI:RD_LO];
    return f;
  endfunction

endpackage

// File: rtl/reg_array.sv
// Architectural register storage: synchronous reset, one write port, three asynchronous read ports.
// Entry 0 is hardwired to read as zero and is never written.
module reg_array
  import regfile_pkg::*;
#(
  parameter int                WIDTH      = DATA_W,
  parameter int                DEPTH      = NUM_REGS,
  parameter logic [WIDTH-1:0]  INIT_VALUE = RESET_VALUE,
  localparam int               AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    rd_addr_c,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset wins over a coincident write; writes to entry 0 are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_VALUE;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];
  assign rd_data_c = (rd_addr_c == '0) ? '0 : mem[rd_addr_c];

endmodule

// File: rtl/reg_file_decode.sv
// Operand stage: instruction field decode, write-address select and register-file reads.
// Define REGFILE_BYPASS_EN to forward bus_w onto bus_a/bus_b when reading the register being written.
module reg_file_decode
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              start_up,
  input  logic [INSTR_W-1:0] instruction,
  input  logic              reg_dst,
  input  logic              reg_wr,
  input  logic [DATA_W-1:0] bus_w,
  output logic [ADDR_W-1:0] rs_out,
  output logic [ADDR_W-1:0] rt_out,
  output logic [ADDR_W-1:0] rw_out,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  reg_fields_t      fields;
  dst_sel_e         dst_sel;
  logic             wr_en;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;
  logic             unused_instr_bits;

  assign fields  = decode_fields(instruction);
  assign dst_sel = dst_sel_e'(reg_dst);

  // Opcode and shamt/funct bits belong to other stages.
  assign unused_instr_bits = ^{instruction[31:26], instruction[10:0]};

  assign rs_out = fields.rs;
  assign rt_out = fields.rt;

  always_comb begin
    rw_out = fields.rt;
    if (dst_sel == DST_RD) begin
      rw_out = fields.rd;
    end
  end

  assign wr_en = reg_wr && (rw_out != ZERO_REG);

  reg_array #(
    .WIDTH      (DATA_W),
    .DEPTH      (NUM_REGS),
    .INIT_VALUE (RESET_VALUE)
  ) u_reg_array (
    .clk       (clk),
    .reset     (start_up),
    .wr_en     (wr_en),
    .wr_addr   (rw_out),
    .wr_data   (bus_w),
    .rd_addr_a (fields.rs),
    .rd_addr_b (fields.rt),
    .rd_addr_c (dbg_addr),
    .rd_data_a (arr_a),
    .rd_data_b (arr_b),
    .rd_data_c (dbg_data)
  );

`ifdef REGFILE_BYPASS_EN
  // Write-through only for a write that will actually commit at the next edge.
  logic wr_commit;
  assign wr_commit = wr_en && !start_up;

  always_comb begin
    bus_a = arr_a;
    bus_b = arr_b;
    if (wr_commit && (rw_out == fields.rs)) begin
      bus_a = bus_w;
    end
    if (wr_commit && (rw_out == fields.rt)) begin
      bus_b = bus_w;
    end
  end
`else
  assign bus_a = arr_a;
  assign bus_b = arr_b;
`endif

endmodule

// File: tb/tb_reg_file_decode.sv
// Directed scoreboard bench for reg_file_decode: expectations are queued with each stimulus
// step and drained against the DUT outputs once the combinational paths have settled.
module tb_reg_file_decode;

  logic        clk;
  logic        start_up;
  logic [31:0] instruction;
  logic        reg_dst;
  logic        reg_wr;
  logic [31:0] bus_w;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rw_out;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  typedef enum int { SIG_RS, SIG_RT, SIG_RW, SIG_BUS_A, SIG_BUS_B, SIG_DBG } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       tag;
  } exp_item_t;

  exp_item_t scoreboard[$];

  reg_file_decode dut (
    .clk         (clk),
    .start_up    (start_up),
    .instruction (instruction),
    .reg_dst     (reg_dst),
    .reg_wr      (reg_wr),
    .bus_w       (bus_w),
    .rs_out      (rs_out),
    .rt_out      (rt_out),
    .rw_out      (rw_out),
    .bus_a       (bus_a),
    .bus_b       (bus_b),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SIG_RS:    return {27'b0, rs_out};
      SIG_RT:    return {27'b0, rt_out};
      SIG_RW:    return {27'b0, rw_out};
      SIG_BUS_A: return bus_a;
      SIG_BUS_B: return bus_b;
      default:   return dbg_data;
    endcase
  endfunction

  task automatic applyStimulus(input logic su, input logic [31:0] instr, input logic dst,
                               input logic wr, input logic [31:0] wdata, input logic [4:0] dbg);
    start_up    = su;
    instruction = instr;
    reg_dst     = dst;
    reg_wr      = wr;
    bus_w       = wdata;
    dbg_addr    = dbg;
  endtask

  task automatic push_expect(input sig_e s, input logic [31:0] e, input string tag);
    exp_item_t it;
    it.sig = s;
    it.exp = e;
    it.tag = tag;
    scoreboard.push_back(it);
  endtask

  task automatic checkOutput();
    exp_item_t   it;
    logic [31:0] obs;
    #1;
    while (scoreboard.size() > 0) begin
      it  = scoreboard.pop_front();
      obs = sample(it.sig);
      total++;
      assert (obs === it.exp) else begin
        bad++;
        $error("[TB] FAIL %s: observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hazard_a;
    logic [31:0] hazard_b;
`ifdef REGFILE_BYPASS_EN
    hazard_a = 32'd2;
    hazard_b = 32'h0000_0055;
`else
    hazard_a = 32'd1;
    hazard_b = 32'd2;
`endif

    $display("[TB] starting reg_file_decode bench");

    // Initial reset
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0);
    tick();

    // Preload reg 7 so the reset sweep has something to clear
    applyStimulus(1'b0, 32'h0000_3800, 1'b1, 1'b1, 32'h0000_0077, 5'd7);
    push_expect(SIG_RW, 32'd7, "preload_rw");
    checkOutput();
    tick();
    applyStimulus(1'b0, 32'h00E7_0000, 1'b0, 1'b0, 32'h0, 5'd7);
    push_expect(SIG_DBG,   32'h0000_0077, "preload_dbg7");
    push_expect(SIG_BUS_A, 32'h0000_0077, "preload_bus_a");
    checkOutput();

    // Reset clears everything
    applyStimulus(1'b1, 32'h00E7_0000, 1'b0, 1'b0, 32'h0, 5'd0);
    tick();
    start_up = 1'b0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      push_expect(SIG_DBG, 32'h0, $sformatf("reset_dbg%0d", a));
      checkOutput();
    end
    push_expect(SIG_BUS_A, 32'h0, "reset_bus_a");
    push_expect(SIG_BUS_B, 32'h0, "reset_bus_b");
    push_expect(SIG_RS,    32'd7, "reset_rs_field");
    push_expect(SIG_RT,    32'd7, "reset_rt_field");
    push_expect(SIG_RW,    32'd7, "reset_rw_rt");
    checkOutput();

    // Write DEADBEEF to rd=8
    applyStimulus(1'b0, 32'h0000_4020, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd8);
    push_expect(SIG_RW,  32'd8, "wr8_rw_rd");
    push_expect(SIG_DBG, 32'h0, "wr8_dbg_before_edge");
    checkOutput();
    tick();
    applyStimulus(1'b0, 32'h0108_0000, 1'b0, 1'b0, 32'h0, 5'd8);
    push_expect(SIG_DBG,   32'hDEAD_BEEF, "wr8_dbg");
    push_expect(SIG_RS,    32'd8,         "rs8_field");
    push_expect(SIG_RT,    32'd8,         "rt8_field");
    push_expect(SIG_BUS_A, 32'hDEAD_BEEF, "rs_eq_rt_bus_a");
    push_expect(SIG_BUS_B, 32'hDEAD_BEEF, "rs_eq_rt_bus_b");
    checkOutput();

    // reg_dst=0 writes rt=9
    applyStimulus(1'b0, 32'h0009_0000, 1'b0, 1'b1, 32'h1234_5678, 5'd9);
    push_expect(SIG_RW, 32'd9, "wr9_rw_rt");
    checkOutput();
    tick();
    reg_wr = 1'b0;
    push_expect(SIG_DBG, 32'h1234_5678, "wr9_dbg");
    checkOutput();
    dbg_addr = 5'd0;
    push_expect(SIG_DBG, 32'h0, "wr9_reg0_untouched");
    checkOutput();
    dbg_addr = 5'd8;
    push_expect(SIG_DBG, 32'hDEAD_BEEF, "wr9_reg8_kept");
    checkOutput();

    // $0 protection
    applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0);
    push_expect(SIG_RW,    32'd0, "r0_rw");
    push_expect(SIG_BUS_A, 32'h0, "r0_bus_a_before");
    checkOutput();
    tick();
    reg_wr = 1'b0;
    push_expect(SIG_DBG,   32'h0, "r0_dbg");
    push_expect(SIG_BUS_A, 32'h0, "r0_bus_a");
    push_expect(SIG_BUS_B, 32'h0, "r0_bus_b");
    checkOutput();

    // Reset priority over a simultaneous write to reg 5; fields keep tracking
    applyStimulus(1'b1, 32'h0120_2800, 1'b1, 1'b1, 32'hA5A5_A5A5, 5'd5);
    push_expect(SIG_RS,    32'd9,          "rstpri_rs_field");
    push_expect(SIG_RW,    32'd5,          "rstpri_rw_field");
    push_expect(SIG_BUS_A, 32'h1234_5678,  "rstpri_bus_a_before");
    checkOutput();
    tick();
    applyStimulus(1'b0, 32'h0120_2800, 1'b1, 1'b0, 32'h0, 5'd5);
    push_expect(SIG_DBG,   32'h0, "rstpri_reg5");
    push_expect(SIG_BUS_A, 32'h0, "rstpri_reg9_cleared");
    checkOutput();
    dbg_addr = 5'd8;
    push_expect(SIG_DBG, 32'h0, "rstpri_reg8_cleared");
    checkOutput();

    // Same-cycle hazard on rs
    applyStimulus(1'b0, 32'h0000_1800, 1'b1, 1'b1, 32'd1, 5'd3);
    tick();
    applyStimulus(1'b0, 32'h0060_1800, 1'b1, 1'b1, 32'd2, 5'd3);
    push_expect(SIG_BUS_A, hazard_a, "hazard_rs_bus_a");
    push_expect(SIG_BUS_B, 32'h0,    "hazard_rs_bus_b_r0");
    push_expect(SIG_DBG,   32'd1,    "hazard_dbg_not_bypassed");
    checkOutput();
    tick();
    reg_wr = 1'b0;
    push_expect(SIG_BUS_A, 32'd2, "hazard_rs_after");
    checkOutput();

    // Same-cycle hazard on rt
    applyStimulus(1'b0, 32'h0003_1800, 1'b1, 1'b1, 32'h0000_0055, 5'd3);
    push_expect(SIG_BUS_B, hazard_b, "hazard_rt_bus_b");
    push_expect(SIG_DBG,   32'd2,    "hazard_rt_dbg");
    checkOutput();
    tick();
    reg_wr = 1'b0;
    push_expect(SIG_BUS_B, 32'h0000_0055, "hazard_rt_after");
    checkOutput();

    // Write disabled leaves state alone
    applyStimulus(1'b0, 32'h0003_1800, 1'b1, 1'b0, 32'hCAFE_F00D, 5'd3);
    tick();
    push_expect(SIG_DBG, 32'h0000_0055, "no_wr_kept");
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
